gx_reset_seq: RTL and testbench

//  Per-channel transceiver reset sequencer. Drives the tx/rx analog and digital resets of one

---
 rtl/gx_reset_seq.sv | 201 ++++++++++++++++++++
 tb/tb_gx_reset_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gx_reset_seq.sv
// Per-channel transceiver reset sequencer: sequences tx/rx analog and digital resets from PLL,
// calibration and CDR status. Optional rx lock timeout is enabled by defining GX_RST_TIMEOUT_EN.
module gx_reset_seq #(
    parameter int T_ANALOG  = 50,
    parameter int T_TXDIG   = 500,
    parameter int T_LTD     = 250,
    parameter int T_TIMEOUT = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic tx_pll_locked_i,
    input  logic tx_pll_cal_busy_i,
    input  logic tx_cal_busy_i,
    input  logic rx_cal_busy_i,
    input  logic rx_is_lockedtodata_i,
    output logic tx_analogreset_o,
    output logic tx_digitalreset_o,
    output logic rx_analogreset_o,
    output logic rx_digitalreset_o,
    output logic tx_ready_o,
    output logic rx_ready_o
);

    localparam int MAX_AB  = (T_ANALOG > T_TXDIG) ? T_ANALOG : T_TXDIG;
    localparam int MAX_ABC = (MAX_AB > T_LTD) ? MAX_AB : T_LTD;
    localparam int MAX_ALL = (MAX_ABC > T_TIMEOUT) ? MAX_ABC : T_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    // Terminal values: a state that must last N counted cycles exits when the count shows N-1.
    localparam logic [CNT_W-1:0] ANA_END = CNT_W'(T_ANALOG - 1);
    localparam logic [CNT_W-1:0] DIG_END = CNT_W'(T_TXDIG - 1);
    localparam logic [CNT_W-1:0] LTD_END = CNT_W'(T_LTD - 1);

    typedef enum logic [1:0] {
        TX_RST      = 2'd0,
        TX_WAIT_PLL = 2'd1,
        TX_WAIT_DIG = 2'd2,
        TX_READY    = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_RST      = 2'd0,
        RX_WAIT_LTD = 2'd1,
        RX_READY    = 2'd2
    } rx_state_t;

    tx_state_t        tx_state;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] rx_cnt;
    logic [4:0]       sync1;
    logic [4:0]       sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {tx_pll_locked_i, tx_pll_cal_busy_i, tx_cal_busy_i,
                      rx_cal_busy_i, rx_is_lockedtodata_i};
            sync2 <= sync1;
        end
    end

    logic pll_locked, pll_cal_busy, tx_cal_busy, rx_cal_busy, locked_to_data, pll_ok;
    assign {pll_locked, pll_cal_busy, tx_cal_busy, rx_cal_busy, locked_to_data} = sync2;
    assign pll_ok = pll_locked & ~pll_cal_busy & ~tx_cal_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state          <= TX_RST;
            tx_cnt            <= '0;
            tx_analogreset_o  <= 1'b1;
            tx_digitalreset_o <= 1'b1;
            tx_ready_o        <= 1'b0;
        end else begin
            case (tx_state)
                TX_RST: begin
                    if (tx_cnt >= ANA_END) begin
                        tx_state         <= TX_WAIT_PLL;
                        tx_cnt           <= '0;
                        tx_analogreset_o <= 1'b0;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_WAIT_PLL: begin
                    if (pll_ok) begin
                        tx_state <= TX_WAIT_DIG;
                        tx_cnt   <= '0;
                    end
                end
                TX_WAIT_DIG: begin
                    // Loss of pll_ok is tested first so it beats a coincident terminal count.
                    if (!pll_ok) begin
                        tx_state <= TX_WAIT_PLL;
                        tx_cnt   <= '0;
                    end else if (tx_cnt >= DIG_END) begin
                        tx_state          <= TX_READY;
                        tx_cnt            <= '0;
                        tx_digitalreset_o <= 1'b0;
                        tx_ready_o        <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_READY: begin
                    if (!pll_locked) begin
                        tx_state          <= TX_RST;
                        tx_cnt            <= '0;
                        tx_analogreset_o  <= 1'b1;
                        tx_digitalreset_o <= 1'b1;
                        tx_ready_o        <= 1'b0;
                    end
                end
                default: begin
                    tx_state          <= TX_RST;
                    tx_cnt            <= '0;
                    tx_analogreset_o  <= 1'b1;
                    tx_digitalreset_o <= 1'b1;
                    tx_ready_o        <= 1'b0;
                end
            endcase
        end
    end

`ifdef GX_RST_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_END = CNT_W'(T_TIMEOUT - 1);
    logic [CNT_W-1:0] rx_to_cnt;
    logic             rx_timeout;

    // Free-running in RX_WAIT_LTD only; any other state holds it at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_to_cnt <= '0;
        end else if (rx_state != RX_WAIT_LTD) begin
            rx_to_cnt <= '0;
        end else if (rx_to_cnt < TO_END) begin
            rx_to_cnt <= rx_to_cnt + 1'b1;
        end
    end
    assign rx_timeout = (rx_to_cnt >= TO_END);
`else
    logic rx_timeout;
    assign rx_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state          <= RX_RST;
            rx_cnt            <= '0;
            rx_analogreset_o  <= 1'b1;
            rx_digitalreset_o <= 1'b1;
            rx_ready_o        <= 1'b0;
        end else begin
            case (rx_state)
                RX_RST: begin
                    if (rx_cnt >= ANA_END && !rx_cal_busy) begin
                        rx_state         <= RX_WAIT_LTD;
                        rx_cnt           <= '0;
                        rx_analogreset_o <= 1'b0;
                    end else if (rx_cnt < ANA_END) begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_WAIT_LTD: begin
                    if (rx_timeout) begin
                        rx_state         <= RX_RST;
                        rx_cnt           <= '0;
                        rx_analogreset_o <= 1'b1;
                    end else if (!locked_to_data) begin
                        rx_cnt <= '0;
                    end else if (rx_cnt >= LTD_END) begin
                        rx_state          <= RX_READY;
                        rx_cnt            <= '0;
                        rx_digitalreset_o <= 1'b0;
                        rx_ready_o        <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_READY: begin
                    if (!locked_to_data) begin
                        rx_state          <= RX_WAIT_LTD;
                        rx_cnt            <= '0;
                        rx_digitalreset_o <= 1'b1;
                        rx_ready_o        <= 1'b0;
                    end
                end
                default: begin
                    rx_state          <= RX_RST;
                    rx_cnt            <= '0;
                    rx_analogreset_o  <= 1'b1;
                    rx_digitalreset_o <= 1'b1;
                    rx_ready_o        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gx_reset_seq.sv
// Bench for gx_reset_seq: directed scenarios plus random status traffic, every cycle compared
// against a behavioural phase model fed through a two-sample input delay.
module tb_gx_reset_seq;
    localparam int T_ANALOG  = 4;
    localparam int T_TXDIG   = 8;
    localparam int T_LTD     = 8;
    localparam int T_TIMEOUT = 32;
`ifdef GX_RST_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    localparam int TXP_RST = 0, TXP_WAIT_PLL = 1, TXP_WAIT_DIG = 2, TXP_READY = 3;
    localparam int RXP_RST = 0, RXP_WAIT = 1, RXP_READY = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic locked, pll_cal, tx_cal, rx_cal, ltd;
    logic tx_analogreset_o, tx_digitalreset_o, rx_analogreset_o, rx_digitalreset_o;
    logic tx_ready_o, rx_ready_o;

    always #10 clk = ~clk;

    gx_reset_seq #(
        .T_ANALOG(T_ANALOG), .T_TXDIG(T_TXDIG), .T_LTD(T_LTD), .T_TIMEOUT(T_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tx_pll_locked_i(locked),
        .tx_pll_cal_busy_i(pll_cal),
        .tx_cal_busy_i(tx_cal),
        .rx_cal_busy_i(rx_cal),
        .rx_is_lockedtodata_i(ltd),
        .tx_analogreset_o(tx_analogreset_o),
        .tx_digitalreset_o(tx_digitalreset_o),
        .rx_analogreset_o(rx_analogreset_o),
        .rx_digitalreset_o(rx_digitalreset_o),
        .tx_ready_o(tx_ready_o),
        .rx_ready_o(rx_ready_o)
    );

    int tests = 0;
    int fails = 0;

    logic [4:0] hist[$];
    int m_tx_ph, m_tx_n, m_rx_ph, m_rx_n, m_rx_t;
    int cyc, tx_rise, rx_rise, tx_ana_fall, rx_ana_fall, rx_ana_rises;
    logic prev_rx_ana;

    function automatic logic [5:0] dut_vec();
        return {tx_analogreset_o, tx_digitalreset_o, rx_analogreset_o, rx_digitalreset_o,
                tx_ready_o, rx_ready_o};
    endfunction

    function automatic logic [5:0] model_out();
        return {m_tx_ph == TXP_RST, m_tx_ph != TXP_READY, m_rx_ph == RXP_RST,
                m_rx_ph != RXP_READY, m_tx_ph == TXP_READY, m_rx_ph == RXP_READY};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_tx_ph = TXP_RST; m_tx_n = 0;
        m_rx_ph = RXP_RST; m_rx_n = 0; m_rx_t = 0;
        hist.delete();
        hist.push_back(5'b0);
        hist.push_back(5'b0);
    endtask

    // Decisions at an edge see the inputs that were present two edges earlier.
    task automatic model_edge();
        logic [4:0] v;
        logic ok;
        hist.push_back({locked, pll_cal, tx_cal, rx_cal, ltd});
        v = hist[hist.size() - 3];
        hist.pop_front();
        ok = v[4] & ~v[3] & ~v[2];
        case (m_tx_ph)
            TXP_RST: begin
                m_tx_n++;
                if (m_tx_n >= T_ANALOG) begin m_tx_ph = TXP_WAIT_PLL; m_tx_n = 0; end
            end
            TXP_WAIT_PLL: if (ok) begin m_tx_ph = TXP_WAIT_DIG; m_tx_n = 0; end
            TXP_WAIT_DIG: begin
                if (!ok) begin
                    m_tx_ph = TXP_WAIT_PLL; m_tx_n = 0;
                end else begin
                    m_tx_n++;
                    if (m_tx_n >= T_TXDIG) m_tx_ph = TXP_READY;
                end
            end
            default: if (!v[4]) begin m_tx_ph = TXP_RST; m_tx_n = 0; end
        endcase
        case (m_rx_ph)
            RXP_RST: begin
                m_rx_n++;
                if (m_rx_n >= T_ANALOG && !v[1]) begin m_rx_ph = RXP_WAIT; m_rx_n = 0; m_rx_t = 0; end
            end
            RXP_WAIT: begin
                m_rx_t++;
                m_rx_n = v[0] ? m_rx_n + 1 : 0;
                if (TIMEOUT_ON && m_rx_t >= T_TIMEOUT) begin
                    m_rx_ph = RXP_RST; m_rx_n = 0;
                end else if (m_rx_n >= T_LTD) begin
                    m_rx_ph = RXP_READY;
                end
            end
            default: if (!v[0]) begin m_rx_ph = RXP_WAIT; m_rx_n = 0; m_rx_t = 0; end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check("outputs", 32'(dut_vec()), 32'(model_out()));
        if (tx_ready_o && tx_rise < 0) tx_rise = cyc;
        if (rx_ready_o && rx_rise < 0) rx_rise = cyc;
        if (!tx_analogreset_o && tx_ana_fall < 0) tx_ana_fall = cyc;
        if (!rx_analogreset_o && rx_ana_fall < 0) rx_ana_fall = cyc;
        if (rx_analogreset_o && !prev_rx_ana) rx_ana_rises++;
        prev_rx_ana = rx_analogreset_o;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive(input logic l, input logic p, input logic t, input logic r, input logic d);
        locked = l; pll_cal = p; tx_cal = t; rx_cal = r; ltd = d;
    endtask

    // Called just after a falling edge; reset rises mid-cycle to exercise the asynchronous path.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1 check("async_reset", 32'(dut_vec()), 32'(6'b111100));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("reset_hold", 32'(dut_vec()), 32'(6'b111100));
        reset = 1'b0;
        cyc = 0; tx_rise = -1; rx_rise = -1; tx_ana_fall = -1; rx_ana_fall = -1;
        rx_ana_rises = 0; prev_rx_ana = 1'b1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 1);
        model_reset();
        @(negedge clk);

        // All status good: tx waits T_ANALOG, one cycle in WAIT_PLL, then T_TXDIG.
        do_reset();
        run(16);
        check("tx_ana_fall", tx_ana_fall, T_ANALOG);
        check("tx_ready_latency", tx_rise, T_ANALOG + 1 + T_TXDIG);
        check("rx_ready_latency", rx_rise, T_ANALOG + T_LTD);

        // One-cycle lock drop reaching the FSM at edge 11 (count 5): WAIT_PLL at 11, WAIT_DIG at 12.
        do_reset();
        run(8);
        drive(0, 0, 0, 0, 1);
        run(1);
        drive(1, 0, 0, 0, 1);
        run(14);
        check("tx_relock_latency", tx_rise, 12 + T_TXDIG);

        // rx_cal_busy high for 20 cycles: low sample at edge 21 reaches the FSM at edge 23.
        drive(1, 0, 0, 1, 1);
        do_reset();
        run(20);
        drive(1, 0, 0, 0, 1);
        run(10);
        check("rx_ana_release", rx_ana_fall, 20 + 1 + 2);

        // CDR drop from RX_READY, then relock.
        drive(1, 0, 0, 0, 1);
        do_reset();
        run(20);
        check("rx_ready_before_drop", rx_ready_o, 1);
        drive(1, 0, 0, 0, 0);
        run(3);
        check("rx_dig_on_drop", rx_digitalreset_o, 1);
        check("rx_ready_on_drop", rx_ready_o, 0);
        check("rx_ana_on_drop", rx_analogreset_o, 0);
        rx_rise = -1;
        drive(1, 0, 0, 0, 1);
        run(12);
        check("rx_relock_latency", rx_rise, 25 + T_LTD);
        check("rx_ana_no_pulse", rx_ana_rises, 0);

        // CDR never locks: analog reset pulses only when the timeout is built in.
        drive(1, 0, 0, 0, 0);
        do_reset();
        run(100);
        check("rx_timeout_pulses", rx_ana_rises, TIMEOUT_ON ? 2 : 0);
        check("rx_ready_never", rx_rise, -1);

        // Reset mid-sequence with tx in WAIT_DIG and rx in READY.
        drive(1, 0, 0, 0, 1);
        do_reset();
        run(12);
        check("tx_in_wait_dig", {tx_analogreset_o, tx_digitalreset_o, tx_ready_o}, 3'b010);
        check("rx_in_ready", rx_ready_o, 1);
        do_reset();
        run(20);

        // Random status traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 19) != 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            run(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
